greenhouse_actuator_sequencer: RTL and testbench
================================================

// Module: greenhouse_actuator_sequencer
// PURPOSE
//  Sits between the combinational greenhouse sensor logic and the PMOD pins.
//  - Qualifies the 10 raw actuator requests (G0-G7 lights, F fan, P pump).
//  - Limits inrush current by allowing at most one actuator turn-on per tick, and staggers light turn-on.
//  - Enforces minimum on-time, minimum off-time, maximum run time and rest lockout on the pump.
// PARAMETERS
//  TICK_DIV         100_000  clk cycles per scheduler tick (>=2)
//  QUAL_TICKS       4        ticks a request bit must differ from its qualified value before it is accepted (>=1)
//  STAGE_TICKS      10       min ticks between successive light turn-ons (>=1)
//  PUMP_MIN_ON      5        min pump run, in ticks (>=1)
//  PUMP_MIN_OFF     20       pump off time after a normal stop, in ticks (>=1)
//  PUMP_MAX_ON      600      max continuous pump run, in ticks (>PUMP_MIN_ON)
//  PUMP_REST        300      pump lockout after hitting PUMP_MAX_ON, in ticks (>=1)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  req           in   10  raw requests, asynchronous: [7:0]=G0..G7, [8]=F, [9]=P
//  drive         out  10  actuator drive, same bit map; goes to PMOD[9:0]
//  pump_lockout  out  1   1 while the pump is in LOCKOUT
//  staging       out  1   1 while any light has qreq=1 but drive=0
// BEHAVIOUR
//  Reset
//   - While rst=1 at a clk edge: drive=0, pump_lockout=0, staging=0.
//   - Sync flops, qreq, qualifier counts, stage timer, tick prescaler and pump timers are all cleared; pump FSM goes to IDLE.
//   - A reset mid-run takes effect at that edge; all drives are 0 on the following cycle.
//  Sync: req passes through a 2-flop synchronizer to give sreq.
//  Tick
//   - Prescaler counts 0..TICK_DIV-1; tick=1 for exactly one clk when count==TICK_DIV-1.
//   - All state below changes only on tick cycles, except reset.
//  Qualify (per bit i), on each tick:
//   - if sreq[i]!=qreq[i], qcnt[i]++; when the count reaches QUAL_TICKS, qreq[i]<=sreq[i] and qcnt[i]<=0.
//   - if sreq[i]==qreq[i], qcnt[i]<=0 (a glitch restarts qualification).
//  Turn-off, same tick that qreq falls: light i or the fan drops immediately. Pump turn-off follows the FSM.
//  Turn-on arbiter
//   - At most one drive bit may rise per tick. Priority: pump > fan > lights.
//   - Fan rises when qreq[8]=1, drive[8]=0, and the pump is not rising this tick.
//   - Light rises when stage_t==0 and neither pump nor fan rises this tick. The lowest index i with qreq[i]=1 and drive[i]=0 rises, and stage_t<=STAGE_TICKS-1.
//   - stage_t decrements by 1 per tick and saturates at 0.
//   - A blocked request stays pending and is retried on the next tick.
//  Pump FSM (drive[9]=1 only in RUN; cnt is in ticks)
//   - IDLE: qreq[9]=1 -> RUN, cnt<=1 (pump rises this tick).
//   - RUN:
//     - if cnt==PUMP_MAX_ON -> LOCKOUT, cnt<=PUMP_REST.
//     - else if qreq[9]=0 and cnt>=PUMP_MIN_ON -> REST, cnt<=PUMP_MIN_OFF.
//     - else cnt++. The max-run check wins over a simultaneous stop request.
//   - REST: cnt--; cnt==1 -> IDLE. Requests are ignored during REST.
//   - LOCKOUT: pump_lockout=1; cnt--; cnt==1 -> IDLE. A request still high on return restarts the pump.
//  Latency: req edge to drive edge = 2 clk + QUAL_TICKS ticks (+ arbitration/stage/FSM ticks), with up to 1 tick of alignment.
//  staging is registered and updated on the cycle after each tick.
// TESTING (TICK_DIV=4 QUAL=2 STAGE=3 MIN_ON=2 MIN_OFF=3 MAX_ON=8 REST=5)
//  1. Reset: drive to 10'h3FF internally, assert rst 1 clk -> drive=0, pump_lockout=0, staging=0 on the next cycle.
//  2. req=10'h0FF held -> G0 rises first, then G1..G7, one per 3 ticks; staging=1 until G7 is on. Drop req -> all lights 0 on one tick.
//  3. req pulses 10'h200 for 1 tick -> no pump drive (qualifier rejects it).
//  4. req=10'h300 rising together -> pump rises on tick n, fan on tick n+1, never on the same tick.
//  5. Pump request high for 1 tick after start -> drive[9] stays on 2 ticks, then off for at least 3 ticks, ignoring a re-request.
//  6. Pump request held -> on 8 ticks, pump_lockout=1 for 5 ticks, pump restarts on the IDLE tick.

Source files
------------

// File: rtl/greenhouse_actuator_sequencer_if.sv
// Greenhouse actuator sequencer: request/drive bundle
// between the sensor logic and the PMOD pins.
interface greenhouse_actuator_sequencer_if;
  logic [9:0] req;
  logic [9:0] drive;
  logic       pump_lockout;
  logic       staging;

  modport master (
    output req,
    input  drive,
    input  pump_lockout,
    input  staging
  );

  modport slave (
    input  req,
    output drive,
    output pump_lockout,
    output staging
  );
endinterface

// File: rtl/greenhouse_actuator_sequencer.sv
// Greenhouse actuator sequencer: request qualification,
// inrush-limited turn-on arbitration and pump protection.
module greenhouse_actuator_sequencer #(
  parameter int TICK_DIV     = 100_000,
  parameter int QUAL_TICKS   = 4,
  parameter int STAGE_TICKS  = 10,
  parameter int PUMP_MIN_ON  = 5,
  parameter int PUMP_MIN_OFF = 20,
  parameter int PUMP_MAX_ON  = 600,
  parameter int PUMP_REST    = 300
) (
  input logic clk,
  input logic rst,
  greenhouse_actuator_sequencer_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int QW = $clog2(QUAL_TICKS + 1);
  localparam int SW = $clog2(STAGE_TICKS + 1);
  localparam int C1 =
    (PUMP_MAX_ON > PUMP_REST) ? PUMP_MAX_ON : PUMP_REST;
  localparam int CM =
    (C1 > PUMP_MIN_OFF) ? C1 : PUMP_MIN_OFF;
  localparam int CW = $clog2(CM + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REST,
    LOCKOUT
  } pump_st_t;

  logic [9:0]    s1;
  logic [9:0]    sreq;
  logic [9:0]    qreq;
  logic [9:0]    qn;
  logic [QW-1:0] qcnt   [10];
  logic [QW-1:0] qcnt_n [10];
  logic [PW-1:0] pcnt;
  logic          tick;
  logic          tick_d;
  logic [SW-1:0] stage_t;
  logic [SW-1:0] stage_n;
  logic [8:0]    drv;
  logic [8:0]    drv_n;
  logic          stg;
  pump_st_t      st;
  pump_st_t      st_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          pump_rise;
  logic          fan_rise;
  logic          light_rise;
  logic [7:0]    pend;
  logic [7:0]    light_oh;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  // A bit must disagree for QUAL_TICKS consecutive ticks.
  always_comb begin
    qn = qreq;
    for (int i = 0; i < 10; i++) begin
      qcnt_n[i] = '0;
      if (sreq[i] != qreq[i]) begin
        if (qcnt[i] == QW'(QUAL_TICKS - 1))
          qn[i] = sreq[i];
        else
          qcnt_n[i] = qcnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    unique case (st)
      IDLE: begin
        if (qn[9]) begin
          st_n  = RUN;
          cnt_n = CW'(1);
        end
      end
      RUN: begin
        if (cnt == CW'(PUMP_MAX_ON)) begin
          st_n  = LOCKOUT;
          cnt_n = CW'(PUMP_REST);
        end else if (!qn[9] &&
                     cnt >= CW'(PUMP_MIN_ON)) begin
          st_n  = REST;
          cnt_n = CW'(PUMP_MIN_OFF);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      REST, LOCKOUT: begin
        if (cnt == CW'(1))
          st_n = IDLE;
        else
          cnt_n = cnt - 1'b1;
      end
      default: st_n = IDLE;
    endcase
  end

  // One rise per tick: pump, then fan, then lowest light.
  always_comb begin
    pump_rise  = (st == IDLE) && qn[9];
    fan_rise   = qn[8] && !drv[8] && !pump_rise;
    pend       = qn[7:0] & ~drv[7:0];
    light_oh   = pend & (~pend + 8'd1);
    light_rise = (stage_t == '0) && !pump_rise &&
                 !fan_rise && (pend != '0);
    drv_n[7:0] = (drv[7:0] & qn[7:0]) |
                 (light_rise ? light_oh : 8'd0);
    drv_n[8]   = qn[8] && (drv[8] || fan_rise);
    if (light_rise)
      stage_n = SW'(STAGE_TICKS - 1);
    else if (stage_t != '0)
      stage_n = stage_t - 1'b1;
    else
      stage_n = stage_t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
    end else if (tick) begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      sreq    <= '0;
      pcnt    <= '0;
      tick_d  <= 1'b0;
      qreq    <= '0;
      drv     <= '0;
      stage_t <= '0;
      stg     <= 1'b0;
      for (int i = 0; i < 10; i++)
        qcnt[i] <= '0;
    end else begin
      s1     <= bus.req;
      sreq   <= s1;
      pcnt   <= tick ? '0 : pcnt + 1'b1;
      tick_d <= tick;
      if (tick) begin
        qreq    <= qn;
        drv     <= drv_n;
        stage_t <= stage_n;
        for (int i = 0; i < 10; i++)
          qcnt[i] <= qcnt_n[i];
      end
      if (tick_d)
        stg <= |(qreq[7:0] & ~drv[7:0]);
    end
  end

  assign bus.drive        = {st == RUN, drv};
  assign bus.pump_lockout = (st == LOCKOUT);
  assign bus.staging      = stg;

endmodule

// File: tb/tb_greenhouse_actuator_sequencer.sv
// Directed bench for greenhouse_actuator_sequencer
// with a small tick divider and short pump timings.
module tb_greenhouse_actuator_sequencer;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  greenhouse_actuator_sequencer_if gif ();

  greenhouse_actuator_sequencer #(
    .TICK_DIV     (TD),
    .QUAL_TICKS   (2),
    .STAGE_TICKS  (3),
    .PUMP_MIN_ON  (2),
    .PUMP_MIN_OFF (3),
    .PUMP_MAX_ON  (8),
    .PUMP_REST    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // idx 0..9 = drive bit, 10 = pump_lockout
  task automatic wait_obs(input int idx, input logic v,
                          input int lim, output int at,
                          output bit ok);
    logic [10:0] o;
    ok = 1'b0;
    at = cyc;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      o = {gif.pump_lockout, gif.drive};
      if (o[idx] === v) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    gif.req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (gif.drive !== 10'h000) begin
      bad++;
      $display("FAIL rst_drive got=%h want=000",
               gif.drive);
    end
    total++;
    if (gif.pump_lockout !== 1'b0) begin
      bad++;
      $display("FAIL rst_lockout got=%b want=0",
               gif.pump_lockout);
    end
    total++;
    if (gif.staging !== 1'b0) begin
      bad++;
      $display("FAIL rst_staging got=%b want=0",
               gif.staging);
    end
    rst = 1'b0;
    gif.req = 10'h3FF;
    settle(25);
    total++;
    if ((gif.drive & 10'h301) !== 10'h301) begin
      bad++;
      $display("FAIL run_before_rst got=%h want=3xx",
               gif.drive);
    end
    rst = 1'b1;
    gif.req = '0;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (gif.drive !== 10'h000) begin
      bad++;
      $display("FAIL midrun_rst_drive got=%h want=000",
               gif.drive);
    end
    total++;
    if (gif.pump_lockout !== 1'b0 ||
        gif.staging !== 1'b0) begin
      bad++;
      $display("FAIL midrun_rst_flags got=%b%b want=00",
               gif.pump_lockout, gif.staging);
    end
    settle(30);
  endtask

  task automatic test_lights();
    int cp;
    int at;
    bit ok;
    logic [9:0] e;
    gif.req = 10'h0FF;
    wait_obs(0, 1'b1, 60, cp, ok);
    total++;
    if (!ok || gif.drive !== 10'h001) begin
      bad++;
      $display("FAIL g0_first got=%h want=001 ok=%0d",
               gif.drive, ok);
    end
    @(negedge clk);
    total++;
    if (gif.staging !== 1'b1) begin
      bad++;
      $display("FAIL staging_on got=%b want=1",
               gif.staging);
    end
    for (int i = 1; i < 8; i++) begin
      wait_obs(i, 1'b1, 40, at, ok);
      e = 10'((1 << (i + 1)) - 1);
      total++;
      if (!ok || gif.drive !== e) begin
        bad++;
        $display("FAIL g%0d_order got=%h want=%h ok=%0d",
                 i, gif.drive, e, ok);
      end
      total++;
      if (at - cp !== 3 * TD) begin
        bad++;
        $display("FAIL g%0d_gap got=%0d want=%0d",
                 i, at - cp, 3 * TD);
      end
      cp = at;
    end
    @(negedge clk);
    total++;
    if (gif.staging !== 1'b0) begin
      bad++;
      $display("FAIL staging_off got=%b want=0",
               gif.staging);
    end
    gif.req = '0;
    wait_obs(0, 1'b0, 40, at, ok);
    total++;
    if (!ok || gif.drive !== 10'h000) begin
      bad++;
      $display("FAIL lights_drop got=%h want=000 ok=%0d",
               gif.drive, ok);
    end
    settle(20);
  endtask

  task automatic test_pulse();
    bit seen;
    seen = 1'b0;
    gif.req = 10'h200;
    settle(TD);
    gif.req = '0;
    settle(TD);
    gif.req = 10'h200;
    settle(TD);
    gif.req = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gif.drive[9] === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL glitch_pump got=%b want=0", seen);
    end
  endtask

  task automatic test_pump_fan();
    int c9;
    int c8;
    bit ok;
    gif.req = 10'h300;
    wait_obs(9, 1'b1, 40, c9, ok);
    total++;
    if (!ok || gif.drive[8] !== 1'b0) begin
      bad++;
      $display("FAIL pump_first got=%h want=200 ok=%0d",
               gif.drive, ok);
    end
    wait_obs(8, 1'b1, 20, c8, ok);
    total++;
    if (!ok || c8 - c9 !== TD) begin
      bad++;
      $display("FAIL fan_after_pump got=%0d want=%0d",
               c8 - c9, TD);
    end
    gif.req = '0;
    settle(80);
    total++;
    if (gif.drive !== 10'h000) begin
      bad++;
      $display("FAIL pf_idle got=%h want=000",
               gif.drive);
    end
  endtask

  task automatic test_min_on_off();
    int r1;
    int f1;
    int r2;
    bit ok;
    gif.req = 10'h200;
    wait_obs(9, 1'b1, 40, r1, ok);
    gif.req = '0;
    wait_obs(9, 1'b0, 40, f1, ok);
    total++;
    if (!ok || f1 - r1 !== 2 * TD) begin
      bad++;
      $display("FAIL min_on got=%0d want=%0d",
               f1 - r1, 2 * TD);
    end
    gif.req = 10'h200;
    wait_obs(9, 1'b1, 60, r2, ok);
    total++;
    if (!ok || r2 - f1 !== 4 * TD) begin
      bad++;
      $display("FAIL min_off got=%0d want=%0d",
               r2 - f1, 4 * TD);
    end
    gif.req = '0;
    settle(80);
    total++;
    if (gif.drive !== 10'h000) begin
      bad++;
      $display("FAIL mo_idle got=%h want=000",
               gif.drive);
    end
  endtask

  task automatic test_max_run();
    int r;
    int f;
    int lf;
    int r3;
    bit ok;
    gif.req = 10'h200;
    wait_obs(9, 1'b1, 40, r, ok);
    wait_obs(9, 1'b0, 60, f, ok);
    total++;
    if (!ok || f - r !== 8 * TD) begin
      bad++;
      $display("FAIL max_on got=%0d want=%0d",
               f - r, 8 * TD);
    end
    total++;
    if (gif.pump_lockout !== 1'b1) begin
      bad++;
      $display("FAIL lockout_set got=%b want=1",
               gif.pump_lockout);
    end
    wait_obs(10, 1'b0, 40, lf, ok);
    total++;
    if (!ok || lf - f !== 5 * TD) begin
      bad++;
      $display("FAIL lockout_len got=%0d want=%0d",
               lf - f, 5 * TD);
    end
    wait_obs(9, 1'b1, 20, r3, ok);
    total++;
    if (!ok || r3 - lf !== TD) begin
      bad++;
      $display("FAIL restart got=%0d want=%0d",
               r3 - lf, TD);
    end
    total++;
    if (gif.pump_lockout !== 1'b0) begin
      bad++;
      $display("FAIL lockout_clr got=%b want=0",
               gif.pump_lockout);
    end
    gif.req = '0;
    settle(80);
    total++;
    if (gif.drive !== 10'h000) begin
      bad++;
      $display("FAIL mr_idle got=%h want=000",
               gif.drive);
    end
  endtask

  initial begin
    test_reset();
    test_lights();
    test_pulse();
    test_pump_fan();
    test_min_on_off();
    test_max_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
